// File: rtl/decode_byte_buffer.sv
// Instruction-byte staging FIFO between fetch and decode: takes 8-byte beats, drops the
// leading bytes after a redirect, and presents a 15-byte MSB-first window with its PC.
// Optional over-consume detection: define DECODE_BUF_OVERCONSUME_CHECK_EN.
module decode_byte_buffer #(
  parameter int DEPTH_BYTES  = 32,
  parameter int FILL_BYTES   = 8,
  parameter int WINDOW_BYTES = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        redirect_valid,
  input  logic [63:0]                 redirect_pc,
  input  logic                        fill_valid,
  output logic                        fill_ready,
  input  logic [8*FILL_BYTES-1:0]     fill_data,
  output logic                        win_valid,
  output logic [8*WINDOW_BYTES-1:0]   win_bytes,
  output logic [3:0]                  win_count,
  output logic [63:0]                 win_pc,
  input  logic                        consume_valid,
  input  logic [3:0]                  consume_bytes,
  output logic                        err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] head;
  logic [CW-1:0] count;
  logic [63:0]   pc;
  logic          drop_pending;
  logic [2:0]    drop_off;

  logic          fill_acc;
  logic [2:0]    skip;
  logic [AW-1:0] tail;
  logic [CW-1:0] req;
  logic [CW-1:0] eff;
  logic [CW-1:0] accepted;

  // Fill handshake: a beat transfers on any cycle where fill_valid and fill_ready are both
  // high and no redirect is present. fill_ready is a function of registered count only.
  assign fill_ready = ({1'b0, count} + (CW+1)'(FILL_BYTES)) <= (CW+1)'(DEPTH_BYTES);
  assign fill_acc   = fill_valid && fill_ready && !redirect_valid;
  assign skip       = drop_pending ? drop_off : 3'd0;
  assign tail       = head + count[AW-1:0];
  assign req        = CW'(consume_bytes);
  assign eff        = consume_valid ? ((req > count) ? count : req) : '0;
  assign accepted   = fill_acc ? (CW'(FILL_BYTES) - CW'(skip)) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      count        <= '0;
      pc           <= '0;
      drop_pending <= 1'b0;
      drop_off     <= 3'd0;
    end else if (redirect_valid) begin
      head         <= '0;
      count        <= '0;
      pc           <= redirect_pc;
      drop_pending <= 1'b1;
      drop_off     <= redirect_pc[2:0];
    end else begin
      head  <= head + eff[AW-1:0];
      pc    <= pc + 64'(eff);
      count <= count - eff + accepted;
      if (fill_acc) drop_pending <= 1'b0;
    end
  end

  // Surviving beat bytes are packed from the tail; the tail index wraps around storage.
  always_ff @(posedge clk) begin
    if (!reset && fill_acc) begin
      for (int k = 0; k < FILL_BYTES; k++) begin
        if (k >= int'(skip))
          mem[AW'(tail + AW'(k) - AW'(skip))] <= fill_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    win_bytes = '0;
    for (int i = 0; i < WINDOW_BYTES; i++) begin
      if (CW'(i) < count)
        win_bytes[8*(WINDOW_BYTES-1-i) +: 8] = mem[AW'(head + AW'(i))];
    end
  end

  assign win_valid = (count != '0);
  assign win_count = (count > CW'(WINDOW_BYTES)) ? 4'(WINDOW_BYTES) : count[3:0];
  assign win_pc    = pc;

`ifdef DECODE_BUF_OVERCONSUME_CHECK_EN
  logic over;
  logic err_q;

  // A consume in a redirect cycle is discarded, so it cannot over-consume.
  assign over = consume_valid && !redirect_valid && ((req > count) || (consume_bytes == 4'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (over) begin
      err_q <= 1'b1;
      $display("ERROR: over-consume %d of %d", consume_bytes, count);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_decode_byte_buffer.sv
// Randomized scoreboard bench for decode_byte_buffer: a byte-queue reference model predicts
// the visible outputs after each edge; a negedge monitor pops and compares them.
module tb_decode_byte_buffer;

  localparam int W = 191;

  logic         clk = 1'b0;
  logic         reset;
  logic         redirect_valid;
  logic [63:0]  redirect_pc;
  logic         fill_valid;
  logic         fill_ready;
  logic [63:0]  fill_data;
  logic         win_valid;
  logic [119:0] win_bytes;
  logic [3:0]   win_count;
  logic [63:0]  win_pc;
  logic         consume_valid;
  logic [3:0]   consume_bytes;
  logic         err;

  decode_byte_buffer dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
    .win_valid(win_valid), .win_bytes(win_bytes), .win_count(win_count), .win_pc(win_pc),
    .consume_valid(consume_valid), .consume_bytes(consume_bytes), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: the buffered bytes in order, plus pc / drop / err.
  logic [7:0]  mq[$];
  logic [63:0] mpc = '0;
  logic        mdrop = 1'b0;
  logic [2:0]  moff = '0;
  logic        merr = 1'b0;
  logic        acc_last;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  function automatic logic [W-1:0] snapshot();
    logic [119:0] wb;
    int n;
    wb = '0;
    n  = mq.size();
    for (int i = 0; i < 15; i++)
      if (i < n) wb[8*(14-i) +: 8] = mq[i];
    return {merr, (n + 8 <= 32), (n != 0), 4'((n > 15) ? 15 : n), mpc, wb};
  endfunction

  task automatic step(input logic rst, input logic rv, input logic [63:0] rpc,
                      input logic fv, input logic [63:0] fd,
                      input logic cv, input logic [3:0] cb);
    int eff;
    int n;
    logic rdy;
    reset = rst; redirect_valid = rv; redirect_pc = rpc;
    fill_valid = fv; fill_data = fd; consume_valid = cv; consume_bytes = cb;
    @(posedge clk);
    acc_last = 1'b0;
    n = mq.size();
    if (rst) begin
      mq.delete(); mpc = '0; mdrop = 1'b0; moff = '0; merr = 1'b0;
    end else if (rv) begin
      mq.delete(); mpc = rpc; mdrop = 1'b1; moff = rpc[2:0];
    end else begin
      rdy = (n + 8 <= 32);
      eff = cv ? ((int'(cb) > n) ? n : int'(cb)) : 0;
`ifdef DECODE_BUF_OVERCONSUME_CHECK_EN
      if (cv && (int'(cb) > n || cb == 4'd0)) merr = 1'b1;
`endif
      for (int i = 0; i < eff; i++) void'(mq.pop_front());
      mpc = mpc + 64'(eff);
      if (fv && rdy) begin
        for (int k = (mdrop ? int'(moff) : 0); k < 8; k++) mq.push_back(fd[8*k +: 8]);
        mdrop = 1'b0;
        acc_last = 1'b1;
      end
    end
    exp_q.push_back(snapshot());
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0);
  endtask

  task automatic check_field(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv)
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    else
      passes++;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_field("err",        128'(err),        128'(e[190]));
      check_field("fill_ready", 128'(fill_ready), 128'(e[189]));
      check_field("win_valid",  128'(win_valid),  128'(e[188]));
      check_field("win_count",  128'(win_count),  128'(e[187:184]));
      check_field("win_pc",     128'(win_pc),     128'(e[183:120]));
      check_field("win_bytes",  128'(win_bytes),  128'(e[119:0]));
    end
  end

  localparam logic [63:0] BEAT = 64'h0807060504030201;

  initial begin
    logic [7:0]  nb;
    logic [63:0] d;
    int wait_cnt;

    step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0);

    // Aligned and offset redirects
    step(1'b0, 1'b1, 64'h1000, 1'b0, 64'd0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 64'd0, 1'b1, BEAT, 1'b0, 4'd0);
    idle();
    step(1'b0, 1'b1, 64'h2005, 1'b0, 64'd0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 64'd0, 1'b1, BEAT, 1'b0, 4'd0);
    idle();

    // Full, backpressure, and release
    step(1'b0, 1'b1, 64'h3000, 1'b0, 64'd0, 1'b0, 4'd0);
    for (int b = 0; b < 4; b++) step(1'b0, 1'b0, 64'd0, 1'b1, {$urandom, $urandom}, 1'b0, 4'd0);
    step(1'b0, 1'b0, 64'd0, 1'b1, {$urandom, $urandom}, 1'b1, 4'd15);
    step(1'b0, 1'b0, 64'd0, 1'b1, {$urandom, $urandom}, 1'b1, 4'd1);
    step(1'b0, 1'b0, 64'd0, 1'b1, {$urandom, $urandom}, 1'b0, 4'd0);
    idle();

    // Incrementing stream across storage wrap, consume 3 per cycle
    step(1'b0, 1'b1, 64'h4000, 1'b0, 64'd0, 1'b0, 4'd0);
    nb = 8'h00;
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = nb + 8'(k);
      step(1'b0, 1'b0, 64'd0, 1'b1, d, 1'b1, 4'd3);
      if (acc_last) nb = nb + 8'd8;
    end

    // Redirect beats simultaneous fill and consume at count=10
    step(1'b0, 1'b1, 64'h5006, 1'b0, 64'd0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 64'd0, 1'b1, BEAT, 1'b0, 4'd0);
    step(1'b0, 1'b0, 64'd0, 1'b1, {$urandom, $urandom}, 1'b0, 4'd0);
    step(1'b0, 1'b1, 64'h6000, 1'b1, BEAT, 1'b1, 4'd4);
    idle();

    // Over-consume, sticky through redirect, cleared by reset
    step(1'b0, 1'b1, 64'h7004, 1'b0, 64'd0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 64'd0, 1'b1, BEAT, 1'b0, 4'd0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 4'd6);
    step(1'b0, 1'b1, 64'h8000, 1'b0, 64'd0, 1'b0, 4'd0);
    idle();
    step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0);
    idle();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 19) == 0, {$urandom, $urandom},
           $urandom_range(0, 9) < 7, {$urandom, $urandom},
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    end
    idle();

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      #1;
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
